mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage ARM pipeline, directly downstream of the execute stage. Registers the execute-stage results into the E/M pipeline register and performs byte or word loads and stores over a req/ack data-memory handshake with variable latency. Freezes the front of the pipeline while an access is outstanding and feeds the M/W register consumed by writeback. Also supplies the M-stage forwarding value to execute.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles `dmem_req` stays high without `dmem_ack` before the access is aborted (range 2..255).

Ports:
- clk  in  1  pipeline clock; everything sampled on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge of clk.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ByteE  in  1 each  condition-qualified execute controls; ByteE selects LDRB/STRB.
- ALUResultE  in  32  address for memory ops, otherwise the result.
- WriteDataE  in  32  store data (shifter output).
- WriteAddrE  in  4  destination register.
- dmem_rdata  in  32  memory read data; valid when dmem_ack=1.
- dmem_ack  in  1  access complete; ignored while dmem_req=0.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address; bits [1:0] are always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data.
- ALUResultM  out  32  forwarding value to execute.
- StallM  out  1  holds the PC, F/D, D/E and E/M registers.
- DataAbortM  out  1  one-cycle pulse when a timeout aborts an access.
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  writeback controls.
- ReadDataW, ALUOutW  out  32  load data and ALU result to writeback.
- WriteAddrW  out  4  destination register to writeback.

## Operation
- E/M register: captures all E inputs each cycle when StallM=0 and holds them when StallM=1.
- memop = MemWriteM | (MemtoRegM & RegWriteM).
- FSM states: IDLE and WAIT.
- IDLE, memop=0: no request, no stall, and the M/W register captures M.
- IDLE, memop=1: assert dmem_req in the same cycle.
  - If dmem_ack is also high that cycle, the access completes with zero wait.
  - Otherwise StallM=1 and the FSM goes to WAIT with the wait counter set to 1.
- WAIT: dmem_req stays high. The outputs dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable.
  - On dmem_ack: the access completes, StallM=0 that cycle, next state IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT without an ack, the access aborts:
    - dmem_req drops on the next cycle.
    - DataAbortM pulses for one cycle.
    - A bubble is written to M/W (RegWriteW=0, PCSrcW=0).
    - StallM drops and the FSM returns to IDLE.
- StallM = memop & ~dmem_ack & ~abort, evaluated combinationally in both states.
- While StallM=1 the M/W register loads a bubble: RegWriteW=0, PCSrcW=0, MemtoRegW=0, data fields don't-care.
- Addressing:
  - dmem_addr = {ALUResultM[31:2], 2'b00}.
  - Word access: be=4'b1111, wdata=WriteDataM, read data passes through unchanged. Address bits [1:0] are ignored.
  - Byte access with k = ALUResultM[1:0]: be = 1<<k, wdata = WriteDataM[7:0] replicated into all four byte lanes, read data = zero-extended byte k of dmem_rdata.
- Stores leave RegWriteW as it arrived; condlogic has already cleared it.
- Reset:
  - State returns to IDLE and the counter clears.
  - dmem_req=0, StallM=0, DataAbortM=0.
  - Every E/M and M/W register clears to 0, so ALUResultM=0 and all W outputs are 0.
  - Reset during WAIT drops dmem_req on that same edge and discards the access.

## Timing
- Non-memory instruction: E inputs at edge n → M at n+1 → W at n+2. Execute can forward ALUResultM from cycle n+1.
- Zero-wait memory op: same two-cycle latency and no stall.
- N-cycle ack (ack in the Nth request cycle, N ≤ TIMEOUT): StallM is high for N−1 cycles. W is valid on the edge after the ack.
- dmem_ack arriving in the same cycle the counter reaches TIMEOUT counts as an ack, not an abort.
- The E/M register does not load during a stall, so a new instruction cannot enter until the ack cycle's edge.

## Test plan
- ALU op: ALUResultE=0x1234, RegWriteE=1, WriteAddrE=3 → ALUResultM=0x1234 after 1 edge; ALUOutW=0x1234, WriteAddrW=3, RegWriteW=1 after 2 edges; no stall.
- Word load with ack after 3 cycles: addr 0x103, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, StallM high 2 cycles, ReadDataW=0xDEADBEEF, MemtoRegW=1.
- Byte store: addr 0x202, WriteDataE=0xAB, zero-wait ack → dmem_we=1, be=0100, wdata=0xABABABAB, no stall. Byte load of the same address with rdata=0x11AB2233 → ReadDataW=0x000000AB.
- Timeout with TIMEOUT=4, ack never given → req high 4 cycles then low, DataAbortM 1-cycle pulse, RegWriteW=0, pipeline resumes.
- Reset asserted in the 2nd WAIT cycle → next cycle dmem_req=0, StallM=0, all W outputs 0, state IDLE. A late ack is ignored.
- Back-to-back load then store, each acked after 2 cycles → two separate stall windows of 1 cycle each, correct order on dmem, no lost instruction.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: E/M and M/W pipeline registers plus the data-memory
// req/ack access controller with timeout abort.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        ByteE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WriteAddrE,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] ALUResultM,
    output logic        StallM,
    output logic        DataAbortM,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WriteAddrW
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Counter value seen in the last request cycle before an abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        pcsrc_m_q;
    logic        regwrite_m_q;
    logic        memtoreg_m_q;
    logic        memwrite_m_q;
    logic        byte_m_q;
    logic [31:0] alu_m_q;
    logic [31:0] wdata_m_q;
    logic [3:0]  waddr_m_q;

    logic        pcsrc_w_q;
    logic        regwrite_w_q;
    logic        memtoreg_w_q;
    logic [31:0] rdata_w_q;
    logic [31:0] alu_w_q;
    logic [3:0]  waddr_w_q;

    logic        memop;
    logic        abort;
    logic        stall;
    logic [1:0]  lane;
    logic [31:0] rdata_fmt;
    logic [3:0]  be;

    assign memop = memwrite_m_q | (memtoreg_m_q & regwrite_m_q);
    assign abort = (state_q == WAIT) & ~dmem_ack & (cnt_q == CNT_LAST);
    assign stall = memop & ~dmem_ack & ~abort;
    assign lane  = alu_m_q[1:0];

    // Byte-lane enables and zero-extended load data for LDRB/STRB.
    always_comb begin
        be        = 4'b1111;
        rdata_fmt = dmem_rdata;
        if (byte_m_q) begin
            be = 4'b0001 << lane;
            unique case (lane)
                2'd0: rdata_fmt = {24'b0, dmem_rdata[7:0]};
                2'd1: rdata_fmt = {24'b0, dmem_rdata[15:8]};
                2'd2: rdata_fmt = {24'b0, dmem_rdata[23:16]};
                2'd3: rdata_fmt = {24'b0, dmem_rdata[31:24]};
                default: rdata_fmt = dmem_rdata;
            endcase
        end
    end

    // Access FSM state and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter WAIT on an unacked request, leave on ack or abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (memop && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ack || abort) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // E/M register holds its contents while an access is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcsrc_m_q    <= 1'b0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            memwrite_m_q <= 1'b0;
            byte_m_q     <= 1'b0;
            alu_m_q      <= 32'd0;
            wdata_m_q    <= 32'd0;
            waddr_m_q    <= 4'd0;
        end else if (!stall) begin
            pcsrc_m_q    <= PCSrcE;
            regwrite_m_q <= RegWriteE;
            memtoreg_m_q <= MemtoRegE;
            memwrite_m_q <= MemWriteE;
            byte_m_q     <= ByteE;
            alu_m_q      <= ALUResultE;
            wdata_m_q    <= WriteDataE;
            waddr_m_q    <= WriteAddrE;
        end
    end

    // M/W register takes a bubble while stalled or on an aborted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcsrc_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            rdata_w_q    <= 32'd0;
            alu_w_q      <= 32'd0;
            waddr_w_q    <= 4'd0;
        end else if (stall || abort) begin
            pcsrc_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
        end else begin
            pcsrc_w_q    <= pcsrc_m_q;
            regwrite_w_q <= regwrite_m_q;
            memtoreg_w_q <= memtoreg_m_q;
            rdata_w_q    <= rdata_fmt;
            alu_w_q      <= alu_m_q;
            waddr_w_q    <= waddr_m_q;
        end
    end

    assign dmem_req   = memop;
    assign dmem_we    = memwrite_m_q;
    assign dmem_addr  = {alu_m_q[31:2], 2'b00};
    assign dmem_be    = be;
    assign dmem_wdata = byte_m_q ? {4{wdata_m_q[7:0]}} : wdata_m_q;

    assign ALUResultM = alu_m_q;
    assign StallM     = stall;
    assign DataAbortM = abort;
    assign PCSrcW     = pcsrc_w_q;
    assign RegWriteW  = regwrite_w_q;
    assign MemtoRegW  = memtoreg_w_q;
    assign ReadDataW  = rdata_w_q;
    assign ALUOutW    = alu_w_q;
    assign WriteAddrW = waddr_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scenario tasks with a transaction-level model of
// the memory stage (TIMEOUT=4).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ByteE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  WriteAddrE;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] ALUResultM;
    logic        StallM, DataAbortM;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [3:0]  WriteAddrW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pc;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic        b;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa;
    } op_t;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .ByteE(ByteE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .WriteAddrE(WriteAddrE),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .ALUResultM(ALUResultM), .StallM(StallM), .DataAbortM(DataAbortM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW)
    );

    // Reference model: what memory should see and what a load returns.
    function automatic logic [3:0] m_be(input logic [31:0] a, input logic b);
        int k;
        k = a % 4;
        return b ? 4'(1 << k) : 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic b);
        return b ? (d % 256) * 32'h0101_0101 : d;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] r,
                                            input logic [31:0] a,
                                            input logic b);
        int k;
        k = a % 4;
        return b ? (r >> (8 * k)) % 256 : r;
    endfunction

    function automatic op_t mk(input logic pc, input logic rw, input logic mtr,
                               input logic mw, input logic b,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [3:0] wa);
        op_t o;
        o.pc = pc; o.rw = rw; o.mtr = mtr; o.mw = mw; o.b = b;
        o.alu = alu; o.wd = wd; o.wa = wa;
        return o;
    endfunction

    task automatic drive(input op_t o);
        PCSrcE = o.pc; RegWriteE = o.rw; MemtoRegE = o.mtr;
        MemWriteE = o.mw; ByteE = o.b;
        ALUResultE = o.alu; WriteDataE = o.wd; WriteAddrE = o.wa;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(mk(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0 || DataAbortM !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl req=%b stall=%b abort=%b want 0 0 0",
                     dmem_req, StallM, DataAbortM);
        end
        checks++;
        if (ALUResultM !== 32'h0 || dmem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_m aluM=%h addr=%h want 0", ALUResultM, dmem_addr);
        end
        checks++;
        if ({PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteAddrW} !== '0) begin
            errors++;
            $display("FAIL reset_w pc=%b rw=%b mtr=%b rd=%h alu=%h wa=%h want 0",
                     PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteAddrW);
        end
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Non-memory ops stream through with two-cycle latency and no stall.
    task automatic test_alu();
        op_t ops[12];
        ops[0] = mk(0, 1, 0, 0, 0, 32'h1234, 32'h0, 4'd3);
        for (int i = 1; i < 10; i++) begin
            logic mtr;
            mtr = 1'($urandom);
            ops[i] = mk(1'($urandom), mtr ? 1'b0 : 1'($urandom), mtr, 1'b0,
                        1'($urandom), $urandom, $urandom, 4'($urandom));
        end
        ops[10] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        ops[11] = ops[10];
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            drive(ops[i]);
            #3;
            if (i >= 1) begin
                checks++;
                if (ALUResultM !== ops[i-1].alu || StallM !== 1'b0 || dmem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_m[%0d] aluM=%h stall=%b req=%b want %h 0 0",
                             i - 1, ALUResultM, StallM, dmem_req, ops[i-1].alu);
                end
            end
            if (i >= 2) begin
                checks++;
                if (ALUOutW !== ops[i-2].alu || WriteAddrW !== ops[i-2].wa ||
                    RegWriteW !== ops[i-2].rw || PCSrcW !== ops[i-2].pc ||
                    MemtoRegW !== ops[i-2].mtr) begin
                    errors++;
                    $display("FAIL alu_w[%0d] alu=%h wa=%h rw=%b pc=%b mtr=%b want %h %h %b %b %b",
                             i - 2, ALUOutW, WriteAddrW, RegWriteW, PCSrcW, MemtoRegW,
                             ops[i-2].alu, ops[i-2].wa, ops[i-2].rw, ops[i-2].pc,
                             ops[i-2].mtr);
                end
            end
        end
    endtask

    task automatic test_word_load();
        int stalls = 0;
        @(posedge clk);
        #1;
        drive(mk(0, 1, 1, 0, 0, 32'h103, 32'h0, 4'd5));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 3; c++) begin
            dmem_ack = (c == 3);
            dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #3;
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
                dmem_addr !== 32'h100 || dmem_be !== 4'hF) begin
                errors++;
                $display("FAIL wload_bus c=%0d req=%b we=%b addr=%h be=%b want 1 0 100 1111",
                         c, dmem_req, dmem_we, dmem_addr, dmem_be);
            end
            if (StallM) stalls++;
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        checks++;
        if (stalls != 2) begin
            errors++;
            $display("FAIL wload_stalls got %0d want 2", stalls);
        end
        checks++;
        if (ReadDataW !== 32'hDEAD_BEEF || MemtoRegW !== 1'b1 ||
            RegWriteW !== 1'b1 || WriteAddrW !== 4'd5) begin
            errors++;
            $display("FAIL wload_w rd=%h mtr=%b rw=%b wa=%h want deadbeef 1 1 5",
                     ReadDataW, MemtoRegW, RegWriteW, WriteAddrW);
        end
    endtask

    task automatic test_byte_access();
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 1, 1, 32'h202, 32'h0000_00AB, 4'd1));
        @(posedge clk);
        #1;
        drive(mk(0, 1, 1, 0, 1, 32'h202, 32'h0, 4'd9));
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0;
        #3;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b0100 ||
            dmem_wdata !== 32'hABAB_ABAB || dmem_addr !== 32'h200 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL bstore req=%b we=%b be=%b wd=%h addr=%h stall=%b want 1 1 0100 abababab 200 0",
                     dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, StallM);
        end
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        dmem_rdata = 32'h11AB_2233;
        #3;
        checks++;
        if (dmem_we !== 1'b0 || dmem_be !== 4'b0100 || StallM !== 1'b0 ||
            RegWriteW !== 1'b0 || WriteAddrW !== 4'd1) begin
            errors++;
            $display("FAIL bload_bus we=%b be=%b stall=%b rwW=%b waW=%h want 0 0100 0 0 1",
                     dmem_we, dmem_be, StallM, RegWriteW, WriteAddrW);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        checks++;
        if (ReadDataW !== 32'h0000_00AB || RegWriteW !== 1'b1 || WriteAddrW !== 4'd9) begin
            errors++;
            $display("FAIL bload_w rd=%h rw=%b wa=%h want 000000ab 1 9",
                     ReadDataW, RegWriteW, WriteAddrW);
        end
    endtask

    // Random word/byte loads and stores acked within the timeout.
    task automatic test_random_mem();
        for (int it = 0; it < 24; it++) begin
            op_t o;
            logic ld;
            int n, stalls;
            logic [31:0] rd;
            ld = 1'($urandom);
            o = mk(ld ? 1'($urandom) : 1'b0, ld, ld, ~ld, 1'($urandom),
                   $urandom, $urandom, 4'($urandom));
            n = $urandom_range(1, 4);
            rd = $urandom;
            stalls = 0;
            @(posedge clk);
            #1;
            drive(o);
            @(posedge clk);
            #1;
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            for (int c = 1; c <= n; c++) begin
                dmem_ack = (c == n);
                dmem_rdata = (c == n) ? rd : $urandom;
                #3;
                checks++;
                if (dmem_req !== 1'b1 || dmem_we !== o.mw ||
                    dmem_addr !== (o.alu & 32'hFFFF_FFFC) ||
                    dmem_be !== m_be(o.alu, o.b) || DataAbortM !== 1'b0 ||
                    (o.mw && dmem_wdata !== m_wdata(o.wd, o.b))) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d] c=%0d req=%b we=%b addr=%h be=%b wd=%h ab=%b want 1 %b %h %b %h 0",
                             it, c, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                             DataAbortM, o.mw, o.alu & 32'hFFFF_FFFC, m_be(o.alu, o.b),
                             m_wdata(o.wd, o.b));
                end
                if (StallM) stalls++;
                @(posedge clk);
                #1;
            end
            dmem_ack = 1'b0;
            checks++;
            if (stalls != n - 1) begin
                errors++;
                $display("FAIL rnd_stalls[%0d] got %0d want %0d", it, stalls, n - 1);
            end
            checks++;
            if (ALUOutW !== o.alu || WriteAddrW !== o.wa || RegWriteW !== o.rw ||
                MemtoRegW !== o.mtr || PCSrcW !== o.pc ||
                (ld && ReadDataW !== m_rdata(rd, o.alu, o.b))) begin
                errors++;
                $display("FAIL rnd_w[%0d] alu=%h wa=%h rw=%b mtr=%b pc=%b rd=%h want %h %h %b %b %b %h",
                         it, ALUOutW, WriteAddrW, RegWriteW, MemtoRegW, PCSrcW, ReadDataW,
                         o.alu, o.wa, o.rw, o.mtr, o.pc, m_rdata(rd, o.alu, o.b));
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        @(posedge clk);
        #1;
        drive(mk(1, 1, 1, 0, 0, 32'h600, 32'h0, 4'd4));
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            #3;
            if (dmem_req) req_cycles++;
            checks++;
            if (StallM !== (c < 4) || DataAbortM !== (c == 4)) begin
                errors++;
                $display("FAIL tmo_c%0d stall=%b abort=%b want %b %b",
                         c, StallM, DataAbortM, c < 4, c == 4);
            end
            @(posedge clk);
            #1;
        end
        #3;
        checks++;
        if (req_cycles != 4 || dmem_req !== 1'b0 || DataAbortM !== 1'b0) begin
            errors++;
            $display("FAIL tmo_end reqcyc=%0d req=%b abort=%b want 4 0 0",
                     req_cycles, dmem_req, DataAbortM);
        end
        checks++;
        if (RegWriteW !== 1'b0 || PCSrcW !== 1'b0) begin
            errors++;
            $display("FAIL tmo_bubble rw=%b pc=%b want 0 0", RegWriteW, PCSrcW);
        end
        drive(mk(0, 1, 0, 0, 0, 32'h77, 32'h0, 4'd6));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checks++;
        if (ALUResultM !== 32'h77 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL tmo_resume aluM=%h stall=%b want 77 0", ALUResultM, StallM);
        end
    endtask

    task automatic test_reset_wait();
        @(posedge clk);
        #1;
        drive(mk(1, 1, 0, 0, 0, 32'h55AA, 32'h0, 4'd7));
        @(posedge clk);
        #1;
        drive(mk(0, 1, 1, 0, 0, 32'h300, 32'h0, 4'd8));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        checks++;
        if (dmem_req !== 1'b1 || StallM !== 1'b1 || ALUOutW !== 32'h55AA) begin
            errors++;
            $display("FAIL rstw_pre req=%b stall=%b aluW=%h want 1 1 55aa",
                     dmem_req, StallM, ALUOutW);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0;
        #3;
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0 || DataAbortM !== 1'b0 ||
            ALUResultM !== 32'h0) begin
            errors++;
            $display("FAIL rstw_ctl req=%b stall=%b abort=%b aluM=%h want 0 0 0 0",
                     dmem_req, StallM, DataAbortM, ALUResultM);
        end
        checks++;
        if ({PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteAddrW} !== '0) begin
            errors++;
            $display("FAIL rstw_w pc=%b rw=%b mtr=%b rd=%h alu=%h wa=%h want 0",
                     PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteAddrW);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        checks++;
        if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || ALUOutW !== 32'h0 ||
            WriteAddrW !== 4'd0) begin
            errors++;
            $display("FAIL rstw_late rw=%b mtr=%b alu=%h wa=%h want 0 0 0 0",
                     RegWriteW, MemtoRegW, ALUOutW, WriteAddrW);
        end
        drive(mk(0, 1, 1, 0, 0, 32'h340, 32'h0, 4'd2));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        #3;
        checks++;
        if (dmem_req !== 1'b1 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL rstw_idle req=%b stall=%b want 1 0", dmem_req, StallM);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        checks++;
        if (ReadDataW !== 32'h0BAD_F00D || WriteAddrW !== 4'd2) begin
            errors++;
            $display("FAIL rstw_load rd=%h wa=%h want 0badf00d 2", ReadDataW, WriteAddrW);
        end
    endtask

    task automatic test_back_to_back();
        op_t ld, st;
        int s_ld = 0, s_st = 0;
        ld = mk(0, 1, 1, 0, 0, 32'h400, 32'h0, 4'd2);
        st = mk(0, 0, 0, 1, 0, 32'h504, 32'hCAFE_F00D, 4'd11);
        @(posedge clk);
        #1;
        drive(ld);
        @(posedge clk);
        #1;
        drive(st);
        for (int c = 1; c <= 2; c++) begin
            dmem_ack = (c == 2);
            dmem_rdata = 32'h1357_9BDF;
            #3;
            checks++;
            if (dmem_addr !== 32'h400 || dmem_we !== 1'b0 || dmem_req !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ld c=%0d addr=%h we=%b req=%b want 400 0 1",
                         c, dmem_addr, dmem_we, dmem_req);
            end
            if (StallM) s_ld++;
            @(posedge clk);
            #1;
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        dmem_ack = 1'b0;
        checks++;
        if (ReadDataW !== 32'h1357_9BDF || WriteAddrW !== 4'd2 || RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ldw rd=%h wa=%h rw=%b want 13579bdf 2 1",
                     ReadDataW, WriteAddrW, RegWriteW);
        end
        for (int c = 1; c <= 2; c++) begin
            dmem_ack = (c == 2);
            #3;
            checks++;
            if (dmem_addr !== 32'h504 || dmem_we !== 1'b1 ||
                dmem_wdata !== 32'hCAFE_F00D || dmem_req !== 1'b1) begin
                errors++;
                $display("FAIL b2b_st c=%0d addr=%h we=%b wd=%h req=%b want 504 1 cafef00d 1",
                         c, dmem_addr, dmem_we, dmem_wdata, dmem_req);
            end
            if (StallM) s_st++;
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        checks++;
        if (s_ld != 1 || s_st != 1) begin
            errors++;
            $display("FAIL b2b_stalls ld=%0d st=%0d want 1 1", s_ld, s_st);
        end
        checks++;
        if (ALUOutW !== 32'h504 || WriteAddrW !== 4'd11 || RegWriteW !== 1'b0 ||
            dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stw alu=%h wa=%h rw=%b req=%b want 504 b 0 0",
                     ALUOutW, WriteAddrW, RegWriteW, dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_word_load();
        test_byte_access();
        test_random_mem();
        test_timeout();
        test_reset_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
